// File: rtl/alu_exec.sv
// Registered execute-stage ALU: single-cycle logic/arithmetic ops plus an optional
// iterative shift-add multiplier, compiled in when ALU_MUL_EN is defined.
module alu_exec #(
  parameter int WIDTH              = 32,
  parameter int ALU_command_length = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ALU_command_length-1:0] func,
  input  logic [WIDTH-1:0]              a,
  input  logic [WIDTH-1:0]              b,
  output logic [WIDTH-1:0]              result,
  output logic                          zero,
  output logic                          busy,
  output logic                          done
);

  localparam logic [ALU_command_length-1:0] FN_AND = ALU_command_length'(0);
  localparam logic [ALU_command_length-1:0] FN_OR  = ALU_command_length'(1);
  localparam logic [ALU_command_length-1:0] FN_ADD = ALU_command_length'(2);
  localparam logic [ALU_command_length-1:0] FN_NOR = ALU_command_length'(3);
  localparam logic [ALU_command_length-1:0] FN_XOR = ALU_command_length'(4);
  localparam logic [ALU_command_length-1:0] FN_MUL = ALU_command_length'(5);
  localparam logic [ALU_command_length-1:0] FN_SUB = ALU_command_length'(6);
  localparam logic [ALU_command_length-1:0] FN_SLT = ALU_command_length'(7);

  // MUL yields zero here; the multi-cycle path intercepts it before this is used.
  function automatic logic [WIDTH-1:0] single_op(
    input logic [ALU_command_length-1:0] fn,
    input logic [WIDTH-1:0]              op_a,
    input logic [WIDTH-1:0]              op_b
  );
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    sa = op_a;
    sb = op_b;
    case (fn)
      FN_AND:  single_op = op_a & op_b;
      FN_OR:   single_op = op_a | op_b;
      FN_ADD:  single_op = op_a + op_b;
      FN_NOR:  single_op = ~(op_a | op_b);
      FN_XOR:  single_op = op_a ^ op_b;
      FN_MUL:  single_op = '0;
      FN_SUB:  single_op = op_a - op_b;
      FN_SLT:  single_op = {{(WIDTH-1){1'b0}}, (sa < sb)};
      default: single_op = '0;
    endcase
  endfunction

  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

`ifdef ALU_MUL_EN
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && func == FN_MUL) state_d = S_MUL;
      S_MUL:   if (cnt_q == CNT_W'(1)) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // The final iteration writes its sum straight into result so done lands in FIN.
  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (func == FN_MUL) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = CNT_W'(WIDTH);
          end else begin
            result_d = single_op(func, a, b);
            zero_d   = (result_d == '0);
            done_d   = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          result_d = acc_step;
          zero_d   = (acc_step == '0);
          done_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
  end

  assign busy = (state_q == S_MUL);
`else
  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    if (start) begin
      result_d = single_op(func, a, b);
      zero_d   = (result_d == '0);
      done_d   = 1'b1;
    end
  end

  assign busy = 1'b0;
`endif

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign done   = done_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec; multiply checks follow ALU_MUL_EN like the design.
module tb_alu_exec;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [2:0]   func;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic         zero;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  alu_exec #(.WIDTH(W), .ALU_command_length(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .func   (func),
    .a      (a),
    .b      (b),
    .result (result),
    .zero   (zero),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    func  = f;
    a     = x;
    b     = y;
    step();
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    func  = 3'd0;
    a     = '0;
    b     = '0;
    step();
    step();
    chk("rst_result", result, 32'h0);
    chk("rst_zero",   {31'b0, zero}, 32'h1);
    chk("rst_busy",   {31'b0, busy}, 32'h0);
    chk("rst_done",   {31'b0, done}, 32'h0);
    rst = 1'b0;
    step();
    chk("idle_done0", {31'b0, done}, 32'h0);
    step();
    chk("idle_done1", {31'b0, done}, 32'h0);

    // back-to-back single-cycle ops, start held high
    issue(3'b010, 32'h0000_000A, 32'h0000_0003);
    chk("add_done", {31'b0, done}, 32'h1);
    chk("add_res",  result, 32'h0000_000D);
    chk("add_zero", {31'b0, zero}, 32'h0);
    issue(3'b110, 32'h0000_000A, 32'h0000_0003);
    chk("sub_done", {31'b0, done}, 32'h1);
    chk("sub_res",  result, 32'h0000_0007);
    issue(3'b000, 32'h0000_000A, 32'h0000_0003);
    chk("and_done", {31'b0, done}, 32'h1);
    chk("and_res",  result, 32'h0000_0002);
    issue(3'b001, 32'h0000_000A, 32'h0000_0003);
    chk("or_done", {31'b0, done}, 32'h1);
    chk("or_res",  result, 32'h0000_000B);
    issue(3'b100, 32'h0000_000A, 32'h0000_0003);
    chk("xor_done", {31'b0, done}, 32'h1);
    chk("xor_res",  result, 32'h0000_0009);
    issue(3'b011, 32'h0000_000A, 32'h0000_0003);
    chk("nor_done", {31'b0, done}, 32'h1);
    chk("nor_res",  result, 32'hFFFF_FFF4);
    start = 1'b0;
    a     = 32'h1234_5678;
    step();
    chk("hold_done", {31'b0, done}, 32'h0);
    chk("hold_res",  result, 32'hFFFF_FFF4);

    // wrap, signed compare, zero flag
    issue(3'b010, 32'hFFFF_FFFF, 32'h0000_0001);
    chk("wrap_res",  result, 32'h0);
    chk("wrap_zero", {31'b0, zero}, 32'h1);
    issue(3'b111, 32'hFFFF_FFFF, 32'h0000_0001);
    chk("slt_neg_res",  result, 32'h1);
    chk("slt_neg_zero", {31'b0, zero}, 32'h0);
    issue(3'b111, 32'h0000_0001, 32'hFFFF_FFFF);
    chk("slt_pos_res",  result, 32'h0);
    chk("slt_pos_zero", {31'b0, zero}, 32'h1);
    start = 1'b0;
    step();

`ifdef ALU_MUL_EN
    issue(3'b101, 32'h0001_2345, 32'h0000_0010);
    start = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      chk($sformatf("mul_busy_%0d", i), {31'b0, busy}, 32'h1);
      chk($sformatf("mul_nodone_%0d", i), {31'b0, done}, 32'h0);
      if (i == 5) begin
        start = 1'b1;
        func  = 3'b010;
        a     = 32'h1;
        b     = 32'h1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    chk("mul_fin_busy", {31'b0, busy}, 32'h0);
    chk("mul_fin_done", {31'b0, done}, 32'h1);
    chk("mul_res",      result, 32'h0012_3450);
    chk("mul_zero",     {31'b0, zero}, 32'h0);
    step();
    chk("mul_done_once", {31'b0, done}, 32'h0);
    chk("mul_res_hold",  result, 32'h0012_3450);

    issue(3'b101, 32'h8000_0001, 32'h0000_0002);
    start = 1'b0;
    for (int i = 1; i <= 32; i++) step();
    chk("mulov_done", {31'b0, done}, 32'h1);
    chk("mulov_res",  result, 32'h0000_0002);
    step();

    issue(3'b101, 32'h0000_0007, 32'h0000_0009);
    start = 1'b0;
    for (int i = 1; i < 10; i++) step();
    chk("midrst_busy_before", {31'b0, busy}, 32'h1);
    rst = 1'b1;
    step();
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    chk("midrst_res",  result, 32'h0);
    chk("midrst_zero", {31'b0, zero}, 32'h1);
    chk("midrst_done", {31'b0, done}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("midrst_nodone_%0d", i), {31'b0, done}, 32'h0);
      step();
    end
`else
    issue(3'b101, 32'h0001_2345, 32'h0000_0010);
    start = 1'b0;
    chk("mul_off_done", {31'b0, done}, 32'h1);
    chk("mul_off_res",  result, 32'h0);
    chk("mul_off_zero", {31'b0, zero}, 32'h1);
    chk("mul_off_busy", {31'b0, busy}, 32'h0);
    issue(3'b001, 32'h0000_00F0, 32'h0000_000F);
    start = 1'b0;
    chk("pre_rst_res", result, 32'h0000_00FF);
    rst = 1'b1;
    step();
    chk("rst2_res",  result, 32'h0);
    chk("rst2_zero", {31'b0, zero}, 32'h1);
    chk("rst2_done", {31'b0, done}, 32'h0);
    rst = 1'b0;
    step();
`endif

    issue(3'b010, 32'h0000_0002, 32'h0000_0002);
    start = 1'b0;
    chk("post_rst_done", {31'b0, done}, 32'h1);
    chk("post_rst_res",  result, 32'h0000_0004);
    step();
    chk("post_rst_done_end", {31'b0, done}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
# alu_exec

Registered execute-stage ALU that consumes the 3-bit function code produced by the ALU control stage and the two operand buses, and returns a registered result plus zero flag. Logical/arithmetic ops finish in one cycle. Multiply is iterative, shift-add, multi-cycle, with a busy/done handshake so the pipeline controller can stall. Sits directly downstream of the ALU control decoder and upstream of the memory/write-back mux.

## Interface
- `WIDTH`, 32, operand/result width in bits.
- `ALU_command_length`, 3, width of function code (fixed encoding below).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request; sampled only in IDLE.
- `func` input `ALU_command_length`: operation code from ALU control.
- `a` input `WIDTH`: operand A.
- `b` input `WIDTH`: operand B.
- `result` output `WIDTH`: registered result, holds until next completion.
- `zero` output 1: registered, 1 iff `result == 0`.
- `busy` output 1: high while a multiply iterates.
- `done` output 1: one-cycle pulse when `result` is updated.

## Operation
- Function encoding:
  - 000 AND, 001 OR, 010 ADD, 011 NOR, 100 XOR.
  - 101 MUL.
  - 110 SUB (a−b).
  - 111 SLT (signed a<b → 1, else 0).
- ADD/SUB wrap modulo 2^WIDTH; no overflow flag. MUL returns low WIDTH bits of a×b.
- States:
  - IDLE: `start`=1 with non-MUL func → compute and register `result`/`zero`, assert `done`, stay IDLE. `start`=1 with MUL → latch a (multiplicand), b (multiplier), clear accumulator, load counter=WIDTH, go MUL.
  - MUL: each cycle, if multiplier LSB=1 then acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter−−. When counter reaches 0 → go FIN.
  - FIN: register acc into `result`/`zero`, assert `done`, go IDLE.
- `start` outside IDLE is ignored; no queuing. `func`/`a`/`b` need only be valid in the cycle `start` is sampled.
- `start` in the same cycle FIN completes is ignored (FIN is not IDLE).
- Reset (any state, including mid-multiply): state=IDLE, `result`=0, `zero`=1, `busy`=0, `done`=0, counter/accumulator cleared. Any in-flight multiply is discarded and produces no `done`.

## Timing
- Reset values: `result`=0, `zero`=1, `busy`=0, `done`=0.
- Single-cycle op: `start` sampled at edge N → `result`/`zero` valid and `done`=1 after edge N+1. `done` is high for exactly one cycle.
- MUL: `start` sampled at edge N → `busy`=1 for cycles N+1 … N+WIDTH. FIN occupies cycle N+WIDTH+1, with `busy`=0 and `done`=1 in that cycle. Total latency is WIDTH+1 cycles.
- Back-to-back single-cycle ops: one accepted per cycle while `start` is held high with changing `func`/`a`/`b`.
- `result`/`zero` change only on `done` or reset.

## Configuration
- `ALU_MUL_EN` defined: MUL path, MUL and FIN states, counter and accumulator are compiled in, as described above.
- `ALU_MUL_EN` undefined:
  - func 101 is a single-cycle op producing `result`=0 (`zero`=1) with `done` after one cycle.
  - `busy` is tied 0.
  - No multiply hardware is present.

## Test plan
- Reset then idle: `rst` high 2 cycles → `result`=0, `zero`=1, `busy`=0, `done`=0. No `done` with `start`=0.
- Single-cycle ops, one per cycle, with a=0x0000_000A, b=0x0000_0003. Each `done` pulses one cycle after its start:
  - ADD → 0x0000_000D.
  - SUB → 0x0000_0007.
  - AND → 0x0000_0002.
  - OR → 0x0000_000B.
  - XOR → 0x0000_0009.
  - NOR → 0xFFFF_FFF4.
- Wrap/SLT/zero:
  - ADD a=0xFFFF_FFFF, b=1 → 0, `zero`=1.
  - SLT a=0xFFFF_FFFF, b=1 → 1.
  - SLT a=1, b=0xFFFF_FFFF → 0, `zero`=1.
- MUL (ALU_MUL_EN): a=0x0001_2345, b=0x0000_0010 → `busy` high 32 cycles, then `done` with `result`=0x0012_3450. A `start` ADD issued during busy produces no extra `done`.
- MUL overflow: a=0x8000_0001, b=0x0000_0002 → `result`=0x0000_0002 after 33 cycles.
- Reset mid-multiply at busy cycle 10 → next cycle `busy`=0, `result`=0, and no `done`. A new ADD 2+2 then returns 4 after one cycle.
